// File: rtl/texture_texel_fetch.sv
// -----------------------------------------------------------------------------
// texture_texel_fetch
//   Upstream feeder of the texture palette LUT. Converts per-pixel fixed-point
//   texture coordinates into a texel address, reads a synchronous texture ROM
//   and returns the 8-bit palette index plus a sideband tag, in order, on a
//   valid/ready output.
//
//   Ports:
//     Clk, Reset        clock, asynchronous active-high reset
//     in_valid/in_ready request handshake; in_u/in_v fixed-point coords, in_tag
//     rom_addr          texel address {ty,tx} to the ROM
//     rom_data          palette index from ROM, one cycle after rom_addr
//     out_valid/ready   output handshake; out_index, out_tag, out_transparent
//
//   Optional feature (macro TEXEL_TRANSPARENT_EN):
//     defined   -> out_transparent flags entries whose index == TRANSP_INDEX
//     undefined -> out_transparent is tied to 0
// -----------------------------------------------------------------------------
module texture_texel_fetch #(
    parameter int         TEX_W_LOG2   = 5,
    parameter int         TEX_H_LOG2   = 5,
    parameter int         UV_W         = 16,
    parameter int         FRAC_BITS    = 8,
    parameter int         TAG_W        = 10,
    parameter logic [7:0] TRANSP_INDEX = 8'd0,
    localparam int        AW           = TEX_W_LOG2 + TEX_H_LOG2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UV_W-1:0]  in_u,
    input  logic [UV_W-1:0]  in_v,
    input  logic [TAG_W-1:0] in_tag,
    output logic [AW-1:0]    rom_addr,
    input  logic [7:0]       rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_index,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_transparent
);

    localparam int DEPTH = 3;

    logic             vld_p0;
    logic [TAG_W-1:0] tag_p0;

    logic [7:0]       idx_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       count;

    logic accept;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit check counts the read already in flight, so the FIFO can never
    // overflow and out_ready has no combinational path to in_ready.
    assign in_ready = !Reset && (({1'b0, count} + {2'b0, vld_p0}) < 3'd3);
    assign accept   = in_valid && in_ready;
    assign push     = vld_p0;
    assign out_valid = (count != 2'd0);
    assign pop      = out_valid && out_ready;

    assign out_index = idx_mem[rd_ptr];
    assign out_tag   = tag_mem[rd_ptr];

    // ---- stage p0: address register (ROM read in progress) ----
    // Integer bits above the texture size are dropped, giving repeat-wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p0   <= 1'b0;
            rom_addr <= '0;
            tag_p0   <= '0;
        end else if (accept) begin
            vld_p0   <= 1'b1;
            rom_addr <= {in_v[FRAC_BITS +: TEX_H_LOG2], in_u[FRAC_BITS +: TEX_W_LOG2]};
            tag_p0   <= in_tag;
        end else begin
            vld_p0   <= 1'b0;
        end
    end

    // ---- stage p1: capture ROM data into the in-order output FIFO ----
    // Storage is reset so that the head reads as zero straight after reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_mem[i] <= '0;
                tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                idx_mem[wr_ptr] <= rom_data;
                tag_mem[wr_ptr] <= tag_p0;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef TEXEL_TRANSPARENT_EN
    logic trn_mem [DEPTH];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                trn_mem[i] <= 1'b0;
            end
        end else if (push) begin
            trn_mem[wr_ptr] <= (rom_data == TRANSP_INDEX);
        end
    end

    assign out_transparent = trn_mem[rd_ptr];
`else
    assign out_transparent = 1'b0;
`endif

endmodule

// File: tb/tb_texture_texel_fetch.sv
module tb_texture_texel_fetch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       in_valid;
    logic       in_ready;
    logic [15:0] in_u;
    logic [15:0] in_v;
    logic [9:0] in_tag;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_index;
    logic [9:0] out_tag;
    logic       out_transparent;

    int total = 0;
    int bad   = 0;
    int npop  = 0;
    int sent  = 0;
    bit acc;
    logic [18:0] q [$];

    logic       ovr_en;
    logic [7:0] ovr_val;

    always #5 Clk = ~Clk;

    // ROM model: 1-cycle read where rom_addr is the ROM's address register.
    assign rom_data = ovr_en ? ovr_val : (rom_addr[7:0] ^ 8'h5A);

    texture_texel_fetch dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_u(in_u), .in_v(in_v), .in_tag(in_tag),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_tag(out_tag),
        .out_transparent(out_transparent)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_idx(input logic [15:0] u, input logic [15:0] v);
        logic [9:0] a;
        a = {v[12:8], u[12:8]};
        return ovr_en ? ovr_val : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic logic exp_trn(input logic [7:0] idx);
`ifdef TEXEL_TRANSPARENT_EN
        return (idx == 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: record accepts into the scoreboard, check pops, then advance.
    task automatic step();
        logic [7:0]  ei;
        logic [18:0] e;
        acc = 1'b0;
        if (in_valid && in_ready) begin
            ei = exp_idx(in_u, in_v);
            q.push_back({exp_trn(ei), in_tag, ei});
            acc = 1'b1;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pop_idx", {24'd0, out_index}, {24'd0, e[7:0]});
                chk("pop_tag", {22'd0, out_tag}, {22'd0, e[17:8]});
                chk("pop_trn", {31'd0, out_transparent}, {31'd0, e[18]});
            end
            npop++;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int k, input int base);
        in_u   = 16'h0300 + 16'(k) * 16'h0100;
        in_v   = 16'h0700;
        in_tag = 10'(base + k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; in_valid = 1'b0; in_u = '0; in_v = '0; in_tag = '0;
        out_ready = 1'b0; ovr_en = 1'b0; ovr_val = 8'h00;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        chk("rst_out_index", {24'd0, out_index}, 32'd0);
        chk("rst_out_tag", {22'd0, out_tag}, 32'd0);
        chk("rst_out_trn", {31'd0, out_transparent}, 32'd0);
        Reset = 1'b0;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge Clk); #1;

        // 1: basic fetch, 163 -> 0xA3 ^ 0x5A = 0xF9
        out_ready = 1'b1;
        in_valid = 1'b1; in_u = 16'h0300; in_v = 16'h0500; in_tag = 10'd7;
        step();
        in_valid = 1'b0;
        chk("t1_rom_addr", {22'd0, rom_addr}, 32'd163);
        chk("t1_ov_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_index", {24'd0, out_index}, 32'hF9);
        chk("t1_out_tag", {22'd0, out_tag}, 32'd7);
        step();
        chk("t1_empty", {31'd0, out_valid}, 32'd0);

        // 2: wrap addressing, tx=1 ty=31 -> 993 = 0x3E1, 0xE1^0x5A = 0xBB
        in_valid = 1'b1; in_u = 16'h2140; in_v = 16'hFF80; in_tag = 10'd9;
        step();
        in_valid = 1'b0;
        chk("t2_rom_addr", {22'd0, rom_addr}, 32'd993);
        step();
        chk("t2_out_index", {24'd0, out_index}, 32'hBB);
        step();

        // 3: backpressure, only 3 accepted, then drain in order
        out_ready = 1'b0; sent = 0; npop = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (sent < 5);
            drive(sent, 100);
            step();
            if (acc) sent++;
        end
        chk("t3_accepted", sent, 32'd3);
        chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_head_tag", {22'd0, out_tag}, 32'd100);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (sent < 5 || q.size() > 0); c++) begin
            in_valid = (sent < 5);
            drive(sent, 100);
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("t3_pops", npop, 32'd5);

        // 4: streaming throughput, 2-cycle latency
        npop = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            drive(i, 200);
            chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
            chk("t4_out_valid", {31'd0, out_valid}, (i >= 2) ? 32'd1 : 32'd0);
            step();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            chk("t4_tail_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        chk("t4_drained", {31'd0, out_valid}, 32'd0);
        chk("t4_pops", npop, 32'd16);

        // 5: reset with 2 buffered + 1 in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            drive(k, 300);
            step();
        end
        in_valid = 1'b0;
        chk("t5_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("t5_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_index", {24'd0, out_index}, 32'd0);
        chk("t5_rst_tag", {22'd0, out_tag}, 32'd0);
        chk("t5_rst_addr", {22'd0, rom_addr}, 32'd0);
        chk("t5_rst_rdy", {31'd0, in_ready}, 32'd0);
        q.delete();
        @(posedge Clk);
        #3 Reset = 1'b0;
        #1;
        chk("t5_rel_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge Clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
            step();
        end
        out_ready = 1'b1;

        // 6: transparency flag for 0x00 and 0x01
        ovr_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ovr_val = 8'(k);
            in_valid = 1'b1; drive(k, 400);
            step();
            in_valid = 1'b0;
            step();
            chk("t6_valid", {31'd0, out_valid}, 32'd1);
            chk("t6_index", {24'd0, out_index}, 32'(k));
            chk("t6_trn", {31'd0, out_transparent}, {31'd0, exp_trn(8'(k))});
            step();
        end
        ovr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
